theta_slice_ctrl: RTL and testbench



---
 rtl/theta_slice_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_theta_slice_ctrl.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/theta_slice_ctrl.sv
// theta_slice_ctrl: slice-serial Keccak theta sequencer over an external
// single-read/single-write synchronous RAM. Primes the parity of the last
// slice, then streams slices 0..N-1, writing each result back in place.
// Optional build macro THETA_ABORT_EN adds an abort input and aborted pulse.
//
// state | meaning
// IDLE  | waiting for start; RAM ports quiet
// PRIME | read of slice N-1 in flight, issue read of slice 0
// RUN   | one read per cycle, one write per cycle once data returns
// FLUSH | reads finished, draining the last returned slice into a write
module theta_slice_ctrl #(
  parameter int N_SLICES = 64,
  parameter int ADDR_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef THETA_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [24:0]       rd_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [24:0]       wr_data
);

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_SLICES - 1);

  typedef enum logic [1:0] {IDLE, PRIME, RUN, FLUSH} state_t;

  state_t              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                rd_en_q, rd_en_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [24:0]         wr_data_q, wr_data_d;
  logic                vld_q, vld_d;       // rd_data holds a slice this cycle
  logic                first_q, first_d;   // next returned slice is slice N-1
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [4:0]          prev_par_q, prev_par_d;
`ifdef THETA_ABORT_EN
  logic                aborted_q, aborted_d;
`endif

  logic [4:0]          cur_par;

  function automatic logic [4:0] col_parity(input logic [24:0] s);
    logic [4:0] p;
    for (int x = 0; x < 5; x++)
      p[x] = s[x] ^ s[x+5] ^ s[x+10] ^ s[x+15] ^ s[x+20];
    return p;
  endfunction

  function automatic logic [24:0] theta_slice(input logic [24:0] s,
                                              input logic [4:0]  cur,
                                              input logic [4:0]  prev);
    logic [24:0] o;
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++)
        o[5*y+x] = s[5*y+x] ^ cur[(x+4)%5] ^ prev[(x+1)%5];
    return o;
  endfunction

  assign cur_par = col_parity(rd_data);

  // Next-state, address sequencing and write datapath
  always_comb begin
    state_d    = state_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    rd_en_d    = rd_en_q;
    rd_addr_d  = rd_addr_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    vld_d      = rd_en_q;
    first_d    = first_q;
    wr_ptr_d   = wr_ptr_q;
    prev_par_d = prev_par_q;
`ifdef THETA_ABORT_EN
    aborted_d  = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = PRIME;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = LAST;
          first_d   = 1'b1;
          wr_ptr_d  = '0;
        end
      end
      PRIME: begin
        state_d   = RUN;
        rd_en_d   = 1'b1;
        rd_addr_d = '0;
      end
      RUN: begin
        if (rd_addr_q == LAST) begin
          rd_en_d = 1'b0;
          state_d = FLUSH;
        end else begin
          rd_addr_d = rd_addr_q + 1'b1;
        end
      end
      FLUSH: begin
        if (!vld_q) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // The slice returned first is N-1: it only seeds the previous parity.
    if (vld_q && (state_q == RUN || state_q == FLUSH)) begin
      prev_par_d = cur_par;
      if (first_q) begin
        first_d = 1'b0;
      end else begin
        wr_en_d   = 1'b1;
        wr_addr_d = wr_ptr_q;
        wr_data_d = theta_slice(rd_data, cur_par, prev_par_q);
        wr_ptr_d  = wr_ptr_q + 1'b1;
      end
    end

`ifdef THETA_ABORT_EN
    if (abort && state_q != IDLE) begin
      state_d   = IDLE;
      busy_d    = 1'b0;
      done_d    = 1'b0;
      rd_en_d   = 1'b0;
      wr_en_d   = 1'b0;
      vld_d     = 1'b0;
      aborted_d = 1'b1;
    end
`endif
  end

  // State and registered outputs, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      vld_q      <= 1'b0;
      first_q    <= 1'b0;
      wr_ptr_q   <= '0;
      prev_par_q <= '0;
`ifdef THETA_ABORT_EN
      aborted_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      vld_q      <= vld_d;
      first_q    <= first_d;
      wr_ptr_q   <= wr_ptr_d;
      prev_par_q <= prev_par_d;
`ifdef THETA_ABORT_EN
      aborted_q  <= aborted_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
`ifdef THETA_ABORT_EN
  assign aborted = aborted_q;
`endif

endmodule

// File: tb/tb_theta_slice_ctrl.sv
// Bench for theta_slice_ctrl: RAM model, golden theta over whole lanes,
// cycle-by-cycle protocol expectations derived from the timing rules.
module tb_theta_slice_ctrl;
  localparam int N  = 64;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          busy, done, rd_en, wr_en;
  logic [AW-1:0] rd_addr, wr_addr;
  logic [24:0]   rd_data = '0;
  logic [24:0]   wr_data;
`ifdef THETA_ABORT_EN
  logic          abort = 1'b0;
  logic          aborted;
`endif

  logic [24:0] mem  [N];
  logic [24:0] orig [N];
  logic [24:0] gold [N];

  int n_tests = 0;
  int n_fail  = 0;

  theta_slice_ctrl #(.N_SLICES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
`ifdef THETA_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .busy(busy), .done(done),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: read data appears the cycle after rd_en
  always @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

  // Golden theta over the whole state taken from orig
  task automatic compute_gold();
    logic [4:0] c [N];
    for (int z = 0; z < N; z++)
      for (int x = 0; x < 5; x++) begin
        c[z][x] = 1'b0;
        for (int y = 0; y < 5; y++) c[z][x] = c[z][x] ^ orig[z][5*y+x];
      end
    for (int z = 0; z < N; z++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++)
          gold[z][5*y+x] = orig[z][5*y+x] ^ c[z][(x+4)%5] ^ c[(z+N-1)%N][(x+1)%5];
  endtask

  // mode 0: zeros, 1: slice 0 = 1, 2: slice N-1 = 1, 3: random
  task automatic load(input int mode);
    for (int i = 0; i < N; i++) begin
      case (mode)
        1:       orig[i] = (i == 0)   ? 25'h1 : 25'h0;
        2:       orig[i] = (i == N-1) ? 25'h1 : 25'h0;
        3:       orig[i] = 25'($urandom());
        default: orig[i] = 25'h0;
      endcase
      mem[i] <= orig[i];
    end
    compute_gold();
    #0;
  endtask

  task automatic snapshot();
    for (int i = 0; i < N; i++) orig[i] = mem[i];
    compute_gold();
  endtask

  // Starts an operation in the current cycle (cycle 0) and follows it
  // cycle by cycle against the timing rules.
  task automatic run_op(input int restart_at, input int rst_at, input bit chain,
                        output int done_cyc, output int n_wr, output int n_rd,
                        output int n_busy);
    bit exp_busy, exp_done, exp_rd, exp_wr;
    done_cyc = 0; n_wr = 0; n_rd = 0; n_busy = 0;
    start = 1'b1;
    for (int k = 1; k <= N + 20; k++) begin
      @(posedge clk); #1;
      start = (k == restart_at);
      if (rst_at != 0 && k > rst_at) begin
        n_tests++;
        if ({busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data} !== '0) begin
          n_fail++;
          $display("FAIL reset_outputs cycle %0d: busy=%b done=%b rd_en=%b wr_en=%b rd_addr=%0d wr_addr=%0d wr_data=%h, required all 0",
                   k, busy, done, rd_en, wr_en, rd_addr, wr_addr, wr_data);
        end
        if (k >= rst_at + 8) begin
          rst_n = 1'b1;
          break;
        end
        continue;
      end
      exp_busy = (k <= N + 3);
      exp_done = (k == N + 4);
      exp_rd   = (k <= N + 1);
      exp_wr   = (k >= 4 && k <= N + 3);
      n_tests++;
      if ({busy, done, rd_en, wr_en} !== {exp_busy, exp_done, exp_rd, exp_wr}) begin
        n_fail++;
        $display("FAIL ctrl cycle %0d: busy/done/rd_en/wr_en=%b%b%b%b required %b%b%b%b",
                 k, busy, done, rd_en, wr_en, exp_busy, exp_done, exp_rd, exp_wr);
      end
      if (rd_en === 1'b1 && exp_rd) begin
        n_tests++;
        if (int'(rd_addr) != ((k == 1) ? N - 1 : k - 2)) begin
          n_fail++;
          $display("FAIL rd_addr cycle %0d: got %0d required %0d", k, rd_addr,
                   (k == 1) ? N - 1 : k - 2);
        end
      end
      if (wr_en === 1'b1 && exp_wr) begin
        n_tests++;
        if (int'(wr_addr) != k - 4 || wr_data !== gold[k-4]) begin
          n_fail++;
          $display("FAIL write cycle %0d: addr=%0d data=%h required addr=%0d data=%h",
                   k, wr_addr, wr_data, k - 4, gold[k-4]);
        end
      end
      if (busy === 1'b1)  n_busy++;
      if (rd_en === 1'b1) n_rd++;
      if (wr_en === 1'b1) n_wr++;
      if (k == rst_at) rst_n = 1'b0;
      if (done === 1'b1) begin
        done_cyc = k;
        if (chain) start = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b required 0", busy); end
    n_tests++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b required 0", done); end
    n_tests++;
    if (rd_en !== 1'b0 || wr_en !== 1'b0) begin
      n_fail++; $display("FAIL reset_en got rd=%b wr=%b required 0 0", rd_en, wr_en);
    end
    n_tests++;
    if (rd_addr !== '0 || wr_addr !== '0) begin
      n_fail++; $display("FAIL reset_addr got rd=%0d wr=%0d required 0 0", rd_addr, wr_addr);
    end
    n_tests++;
    if (wr_data !== '0) begin n_fail++; $display("FAIL reset_wr_data got %h required 0", wr_data); end
  endtask

  task automatic test_all_zero();
    int dc, nw, nr, nb;
    load(0);
    run_op(0, 0, 0, dc, nw, nr, nb);
    n_tests++;
    if (dc != N + 4) begin n_fail++; $display("FAIL zero_done_cycle got %0d required %0d", dc, N + 4); end
    n_tests++;
    if (nw != N || nr != N + 1) begin
      n_fail++; $display("FAIL zero_counts got wr=%0d rd=%0d required %0d %0d", nw, nr, N, N + 1);
    end
    n_tests++;
    if (nb != N + 3) begin n_fail++; $display("FAIL zero_busy_cycles got %0d required %0d", nb, N + 3); end
    for (int z = 0; z < N; z++) begin
      n_tests++;
      if (mem[z] !== 25'h0) begin n_fail++; $display("FAIL zero_mem[%0d] got %h required 0", z, mem[z]); end
    end
  endtask

  task automatic test_single_bit(input int mode);
    int dc, nw, nr, nb;
    int hot;
    logic [24:0] exp;
    hot = (mode == 1) ? 0 : N - 1;
    load(mode);
    run_op(0, 0, 0, dc, nw, nr, nb);
    for (int z = 0; z < N; z++) begin
      if (z == hot)               exp = 25'h0210843;
      else if (z == (hot + 1) % N) exp = 25'h1084210;
      else                        exp = 25'h0;
      n_tests++;
      if (mem[z] !== exp) begin
        n_fail++; $display("FAIL bit%0d_mem[%0d] got %h required %h", mode, z, mem[z], exp);
      end
    end
  endtask

  task automatic test_random();
    int dc, nw, nr, nb;
    for (int it = 0; it < 3; it++) begin
      load(3);
      run_op(0, 0, 0, dc, nw, nr, nb);
      n_tests++;
      if (nw != N || nr != N + 1 || dc != N + 4) begin
        n_fail++; $display("FAIL rand_counts got wr=%0d rd=%0d done=%0d required %0d %0d %0d",
                           nw, nr, dc, N, N + 1, N + 4);
      end
      for (int z = 0; z < N; z++) begin
        n_tests++;
        if (mem[z] !== gold[z]) begin
          n_fail++; $display("FAIL rand_mem[%0d] got %h required %h", z, mem[z], gold[z]);
        end
      end
    end
  endtask

  task automatic test_start_while_busy();
    int dc, nw, nr, nb;
    load(3);
    run_op(10, 0, 0, dc, nw, nr, nb);
    n_tests++;
    if (dc != N + 4 || nw != N) begin
      n_fail++; $display("FAIL restart_done got done=%0d wr=%0d required %0d %0d", dc, nw, N + 4, N);
    end
    // A second accepted start would show up as busy here.
    @(posedge clk); #1;
    n_tests++;
    if (busy !== 1'b0) begin n_fail++; $display("FAIL restart_idle busy=%b required 0", busy); end
    for (int z = 0; z < N; z++) begin
      n_tests++;
      if (mem[z] !== gold[z]) begin
        n_fail++; $display("FAIL restart_mem[%0d] got %h required %h", z, mem[z], gold[z]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int dc, nw, nr, nb;
    load(3);
    run_op(0, 20, 0, dc, nw, nr, nb);
    n_tests++;
    if (dc != 0) begin n_fail++; $display("FAIL rst_no_done got done cycle %0d required none", dc); end
    // Writes issued in cycles 4..20 cover slices 0..16.
    for (int z = 0; z < N; z++) begin
      n_tests++;
      if (mem[z] !== ((z <= 16) ? gold[z] : orig[z])) begin
        n_fail++; $display("FAIL rst_mem[%0d] got %h required %h", z, mem[z],
                           (z <= 16) ? gold[z] : orig[z]);
      end
    end
    @(posedge clk); #1;
    load(3);
    run_op(0, 0, 0, dc, nw, nr, nb);
    n_tests++;
    if (dc != N + 4 || nw != N || nr != N + 1) begin
      n_fail++; $display("FAIL rst_rerun got done=%0d wr=%0d rd=%0d required %0d %0d %0d",
                         dc, nw, nr, N + 4, N, N + 1);
    end
    for (int z = 0; z < N; z++) begin
      n_tests++;
      if (mem[z] !== gold[z]) begin
        n_fail++; $display("FAIL rst_rerun_mem[%0d] got %h required %h", z, mem[z], gold[z]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int dc, nw, nr, nb;
    load(3);
    run_op(0, 0, 1, dc, nw, nr, nb);
    for (int z = 0; z < N; z++) begin
      n_tests++;
      if (mem[z] !== gold[z]) begin
        n_fail++; $display("FAIL b2b_first_mem[%0d] got %h required %h", z, mem[z], gold[z]);
      end
    end
    // start is held through the done cycle: the second run begins here.
    snapshot();
    run_op(0, 0, 0, dc, nw, nr, nb);
    n_tests++;
    if (dc != N + 4 || nw != N) begin
      n_fail++; $display("FAIL b2b_second got done=%0d wr=%0d required %0d %0d", dc, nw, N + 4, N);
    end
    for (int z = 0; z < N; z++) begin
      n_tests++;
      if (mem[z] !== gold[z]) begin
        n_fail++; $display("FAIL b2b_second_mem[%0d] got %h required %h", z, mem[z], gold[z]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) mem[i] <= '0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_all_zero();
    @(posedge clk); #1;
    test_single_bit(1);
    @(posedge clk); #1;
    test_single_bit(2);
    @(posedge clk); #1;
    test_random();
    @(posedge clk); #1;
    test_start_while_busy();
    @(posedge clk); #1;
    test_reset_mid();
    @(posedge clk); #1;
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
